// File: rtl/line_buffer.sv
// ============================================================================
// Module   : line_buffer
// Brief    : Circular line store with a TAPS-wide wrapping read window.
//            Optional macro LINEBUF_REG_OUT_EN registers the window output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module line_buffer #(
  parameter int DATA_W   = 8,
  parameter int LINE_LEN = 480,
  parameter int TAPS     = 6
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [DATA_W-1:0]        i_data,
  input  logic                     i_data_valid,
  input  logic                     i_rd_data,
  output logic [TAPS*DATA_W-1:0]   o_data
);

  localparam int                  c_PTR_W   = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
  localparam logic [c_PTR_W-1:0]  c_LAST    = c_PTR_W'(LINE_LEN - 1);
  localparam logic [c_PTR_W:0]    c_LEN_EXT = (c_PTR_W + 1)'(LINE_LEN);

  logic [DATA_W-1:0]      r_mem [LINE_LEN];
  logic [c_PTR_W-1:0]     r_wr_ptr;
  logic [c_PTR_W-1:0]     r_rd_ptr;
  logic [c_PTR_W-1:0]     w_tap_addr [TAPS];
  logic [TAPS*DATA_W-1:0] w_window;

  // Storage is deliberately not reset; writes are blocked while reset is held.
  always_ff @(posedge i_clk) begin
    if (i_rst && i_data_valid) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_data_valid) begin
        r_wr_ptr <= (r_wr_ptr == c_LAST) ? '0 : r_wr_ptr + 1'b1;
      end
      if (i_rd_data) begin
        r_rd_ptr <= (r_rd_ptr == c_LAST) ? '0 : r_rd_ptr + 1'b1;
      end
    end
  end

  // rd_ptr < LINE_LEN and the reduced offset < LINE_LEN, so one conditional
  // subtract is enough to wrap each tap address.
  generate
    for (genvar k = 0; k < TAPS; k++) begin : g_taps
      localparam logic [c_PTR_W:0] c_OFF = (c_PTR_W + 1)'(k % LINE_LEN);
      logic [c_PTR_W:0] w_sum;

      assign w_sum         = {1'b0, r_rd_ptr} + c_OFF;
      assign w_tap_addr[k] = c_PTR_W'((w_sum >= c_LEN_EXT) ? (w_sum - c_LEN_EXT) : w_sum);
      assign w_window[k*DATA_W +: DATA_W] = r_mem[w_tap_addr[k]];
    end
  endgenerate

`ifdef LINEBUF_REG_OUT_EN
  logic [TAPS*DATA_W-1:0] r_out;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_out <= '0;
    end else begin
      r_out <= w_window;
    end
  end

  assign o_data = r_out;
`else
  assign o_data = w_window;
`endif

endmodule

`default_nettype wire

// File: tb/tb_line_buffer.sv
// ============================================================================
// Module   : tb_line_buffer
// Brief    : Self-checking bench for line_buffer against an array-based model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_line_buffer;

  localparam int DW = 8;
  localparam int LL = 480;
  localparam int TP = 6;
  localparam int OW = DW * TP;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] data;
  logic          data_valid;
  logic          rd_data;
  logic [OW-1:0] dout;

  int n_compared   = 0;
  int n_mismatched = 0;

  // Reference model: plain array and integer pointers
  logic [DW-1:0] m_mem [LL];
  int            m_wr;
  int            m_rd;
  logic [OW-1:0] m_reg_out;

  line_buffer #(.DATA_W(DW), .LINE_LEN(LL), .TAPS(TP)) dut (
    .i_clk        (clk),
    .i_rst        (rst_n),
    .i_data       (data),
    .i_data_valid (data_valid),
    .i_rd_data    (rd_data),
    .o_data       (dout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [OW-1:0] model_window();
    logic [OW-1:0] w;
    for (int k = 0; k < TP; k++) begin
      w[k*DW +: DW] = m_mem[(m_rd + k) % LL];
    end
    return w;
  endfunction

  function automatic logic [OW-1:0] expected();
`ifdef LINEBUF_REG_OUT_EN
    return m_reg_out;
`else
    return model_window();
`endif
  endfunction

  function automatic logic [OW-1:0] pack6(input int b0, input int b1, input int b2,
                                          input int b3, input int b4, input int b5);
    return {DW'(b5), DW'(b4), DW'(b3), DW'(b2), DW'(b1), DW'(b0)};
  endfunction

  // One clock: drive inputs, model the edge, leave inputs idle 1ns after it.
  task automatic cycle(input logic dv, input logic [DW-1:0] d, input logic rd);
    data_valid = dv;
    data       = d;
    rd_data    = rd;
    @(posedge clk);
    m_reg_out = model_window();
    if (dv) begin
      m_mem[m_wr] = d;
      m_wr = (m_wr + 1) % LL;
    end
    if (rd) m_rd = (m_rd + 1) % LL;
    #1;
    data_valid = 1'b0;
    rd_data    = 1'b0;
  endtask

  initial begin
    logic [OW-1:0] all_aa;
    all_aa     = {TP{8'hAA}};
    rst_n      = 1'b0;
    data       = '0;
    data_valid = 1'b1;
    rd_data    = 1'b1;
    m_wr       = 0;
    m_rd       = 0;
    m_reg_out  = '0;
    for (int i = 0; i < LL; i++) m_mem[i] = '0;
    repeat (3) @(posedge clk);
`ifdef LINEBUF_REG_OUT_EN
    #1 check("reset_out_zero", dout, '0);
`endif
    @(negedge clk);
    rst_n      = 1'b1;
    data_valid = 1'b0;
    rd_data    = 1'b0;

    // Fill one line with addr mod 256
    for (int i = 0; i < LL; i++) cycle(1'b1, DW'(i % 256), 1'b0);
    cycle(1'b0, '0, 1'b0);
    check("fill_model", dout, expected());
    check("fill_const", dout, pack6(0, 1, 2, 3, 4, 5));

    // Read advance by 10
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, '0, 1'b1);
      check("adv_step", dout, expected());
    end
    cycle(1'b0, '0, 1'b0);
    check("adv_const", dout, pack6(10, 11, 12, 13, 14, 15));

    // Advance to 477 and check the wrapped window
    while (m_rd != 477) begin
      cycle(1'b0, '0, 1'b1);
      check("adv_to_477", dout, expected());
    end
    cycle(1'b0, '0, 1'b0);
    check("wrap_const", dout, pack6(221, 222, 223, 0, 1, 2));

    // Second line of 0xAA starts at address 0, reads wrap past the end
    for (int i = 0; i < LL; i++) begin
      cycle(1'b1, 8'hAA, 1'($urandom_range(0, 1)));
      check("overwrite", dout, expected());
    end
    for (int i = 0; i < 20; i++) cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b0);
    check("aa_const", dout, all_aa);

    // Random concurrent writes and read advances
    for (int i = 0; i < 600; i++) begin
      cycle(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)));
      check("random", dout, expected());
    end

    // Simultaneous write/advance, then asynchronous reset mid-line
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, DW'($urandom), 1'b1);
      check("simul", dout, expected());
    end
    #3 rst_n = 1'b0;
    m_wr = 0;
    m_rd = 0;
    m_reg_out = '0;
    #1 check("async_reset", dout, expected());
    data_valid = 1'b1;
    rd_data    = 1'b1;
    data       = 8'h77;
    repeat (2) @(posedge clk);
    #1 check("reset_ignores_inputs", dout, expected());
    @(negedge clk);
    rst_n      = 1'b1;
    data_valid = 1'b0;
    rd_data    = 1'b0;
    cycle(1'b1, 8'h5C, 1'b0);
    check("post_reset_write", dout, expected());
    cycle(1'b0, '0, 1'b0);
    check("post_reset_model", dout, expected());
    check("post_reset_addr0", {{(OW-DW){1'b0}}, dout[DW-1:0]}, {{(OW-DW){1'b0}}, 8'h5C});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

`default_nettype wire
